// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types for the systolic wavefront sequencer.
// Default widths, FSM state, latched config bundle, legality check.
package systolic_pkg;

    localparam int WF_ROWS   = 4;
    localparam int WF_LEN_W  = 8;
    localparam int WF_TILE_W = 8;
    localparam int WF_LANE_W = $clog2(WF_ROWS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } wf_state_t;

    // Run configuration captured on the accepting edge.
    typedef struct packed {
        logic [WF_LEN_W-1:0]  len;
        logic [WF_TILE_W-1:0] tiles;
        logic [WF_LANE_W-1:0] lanes;
        logic                 reverse;
    } wf_cfg_t;

    // One lane's flags as carried down the skew line.
    typedef struct packed {
        logic en;
        logic first;
        logic last;
    } wf_lane_t;

    function automatic logic wf_cfg_legal(input wf_cfg_t c,
                                          input int      rows);
        return (c.len != '0)
            && (c.tiles != '0)
            && (c.lanes != '0)
            && (int'(c.lanes) <= rows);
    endfunction

endpackage

// File: rtl/systolic_wavefront_sequencer_skew.sv
// wavefront_skew_line: ROWS-deep shift register of lane flags.
// Ports: clk, rst_n (sync, low), hold_i (stall), clear_i (abort),
//        keep_i (stages in use), din_i (leading lane), tap_o (per delay).
module wavefront_skew_line
    import systolic_pkg::*;
#(
    parameter int ROWS = WF_ROWS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold_i,
    input  logic                clear_i,
    input  logic [ROWS-1:0]     keep_i,
    input  wf_lane_t            din_i,
    output wf_lane_t [ROWS-1:0] tap_o
);

    wf_lane_t [ROWS-1:0] sr_q;
    wf_lane_t [ROWS-1:0] sr_d;

    // Stages beyond the active lane count are forced empty so that a
    // following run with more lanes never sees leftovers of this one.
    always_comb begin
        sr_d = '0;
        if (keep_i[0]) begin
            sr_d[0] = din_i;
        end
        for (int i = 1; i < ROWS; i++) begin
            if (keep_i[i]) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            sr_q <= '0;
        end else if (!hold_i) begin
            sr_q <= sr_d;
        end
    end

    assign tap_o = sr_q;

endmodule

// File: rtl/systolic_wavefront_sequencer.sv
// systolic_wavefront_sequencer: skewed lane-enable generator for an
// array edge. Inputs: clk, rst_n (sync, low), start, cfg_len/tiles/
// lanes/reverse, stall, abort. Outputs: lane_en/first/last per lane,
// tile_idx, busy, done (pulse), err (pulse on illegal start).
module systolic_wavefront_sequencer
    import systolic_pkg::*;
#(
    parameter int ROWS   = WF_ROWS,
    parameter int LEN_W  = WF_LEN_W,
    parameter int TILE_W = WF_TILE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic [TILE_W-1:0]         cfg_tiles,
    input  logic [$clog2(ROWS+1)-1:0] cfg_lanes,
    input  logic                      cfg_reverse,
    input  logic                      stall,
    input  logic                      abort,
    output logic [ROWS-1:0]           lane_en,
    output logic [ROWS-1:0]           lane_first,
    output logic [ROWS-1:0]           lane_last,
    output logic [TILE_W-1:0]         tile_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    wf_state_t            state_q, state_d;
    wf_cfg_t              cfg_q, cfg_d;
    wf_cfg_t              cfg_in;
    logic [WF_LEN_W-1:0]  k_q, k_d;
    logic [WF_TILE_W-1:0] t_q, t_d;
    logic [WF_LANE_W-1:0] dc_q, dc_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    wf_lane_t             lead;
    wf_lane_t [ROWS-1:0]  tap;
    logic [ROWS-1:0]      keep;

    always_comb begin
        cfg_in.len     = WF_LEN_W'(cfg_len);
        cfg_in.tiles   = WF_TILE_W'(cfg_tiles);
        cfg_in.lanes   = WF_LANE_W'(cfg_lanes);
        cfg_in.reverse = cfg_reverse;
    end

    // Leading-lane sequencing. 'lead' is what the first skew stage
    // shows next cycle; k_q/t_q describe the cycle it currently shows.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        k_d     = k_q;
        t_d     = t_q;
        dc_d    = dc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lead    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (wf_cfg_legal(cfg_in, ROWS)) begin
                        state_d    = ISSUE;
                        cfg_d      = cfg_in;
                        k_d        = '0;
                        t_d        = '0;
                        busy_d     = 1'b1;
                        lead.en    = 1'b1;
                        lead.first = 1'b1;
                        lead.last  = (cfg_in.len == WF_LEN_W'(1));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (k_q == cfg_q.len - WF_LEN_W'(1)) begin
                    if (t_q == cfg_q.tiles - WF_TILE_W'(1)) begin
                        if (cfg_q.lanes == WF_LANE_W'(1)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            t_d     = '0;
                        end else begin
                            state_d = DRAIN;
                            dc_d    = cfg_q.lanes - WF_LANE_W'(1);
                        end
                    end else begin
                        t_d        = t_q + WF_TILE_W'(1);
                        k_d        = '0;
                        lead.en    = 1'b1;
                        lead.first = 1'b1;
                        lead.last  = (cfg_q.len == WF_LEN_W'(1));
                    end
                end else begin
                    k_d       = k_q + WF_LEN_W'(1);
                    lead.en   = 1'b1;
                    lead.last = (k_q + WF_LEN_W'(2) == cfg_q.len);
                end
            end
            DRAIN: begin
                if (dc_q == WF_LANE_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    t_d     = '0;
                    dc_d    = '0;
                end else begin
                    dc_d = dc_q - WF_LANE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            k_q     <= '0;
            t_q     <= '0;
            dc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            k_q     <= k_d;
            t_q     <= t_d;
            dc_q    <= dc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Mask follows the config the skew line will hold next cycle, so
    // the accepting edge already trims stages to the new lane count.
    always_comb begin
        keep = '0;
        for (int j = 0; j < ROWS; j++) begin
            keep[j] = (j < int'(cfg_d.lanes));
        end
    end

    wavefront_skew_line #(
        .ROWS (ROWS)
    ) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold_i  (stall),
        .clear_i (abort),
        .keep_i  (keep),
        .din_i   (lead),
        .tap_o   (tap)
    );

    // Lane i reads the stage whose delay matches its skew position.
    always_comb begin
        int d;
        lane_en    = '0;
        lane_first = '0;
        lane_last  = '0;
        d          = 0;
        for (int i = 0; i < ROWS; i++) begin
            if (i < int'(cfg_q.lanes)) begin
                d = cfg_q.reverse ? int'(cfg_q.lanes) - 1 - i : i;
                for (int j = 0; j < ROWS; j++) begin
                    if (j == d) begin
                        lane_en[i]    = tap[j].en;
                        lane_first[i] = tap[j].first;
                        lane_last[i]  = tap[j].last;
                    end
                end
            end
        end
    end

    assign tile_idx = TILE_W'(t_q);
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_systolic_wavefront_sequencer.sv
// tb_systolic_wavefront_sequencer: vector table plus hand sequences;
// expected per-cycle outputs are queued at start and popped each cycle.
module tb_systolic_wavefront_sequencer;
    import systolic_pkg::*;

    localparam int ROWS   = 4;
    localparam int LEN_W  = 8;
    localparam int TILE_W = 8;
    localparam int LW     = $clog2(ROWS + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [TILE_W-1:0] cfg_tiles = '0;
    logic [LW-1:0]     cfg_lanes = '0;
    logic              cfg_reverse = 1'b0;
    logic              stall = 1'b0;
    logic              abort = 1'b0;
    logic [ROWS-1:0]   lane_en, lane_first, lane_last;
    logic [TILE_W-1:0] tile_idx;
    logic              busy, done, err;

    always #5 clk = ~clk;

    systolic_wavefront_sequencer #(
        .ROWS   (ROWS),
        .LEN_W  (LEN_W),
        .TILE_W (TILE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_len     (cfg_len),
        .cfg_tiles   (cfg_tiles),
        .cfg_lanes   (cfg_lanes),
        .cfg_reverse (cfg_reverse),
        .stall       (stall),
        .abort       (abort),
        .lane_en     (lane_en),
        .lane_first  (lane_first),
        .lane_last   (lane_last),
        .tile_idx    (tile_idx),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [ROWS-1:0]   en;
        logic [ROWS-1:0]   first;
        logic [ROWS-1:0]   last;
        logic [TILE_W-1:0] tile;
        bit                chk_tile;
        logic              busy;
        logic              done;
        logic              err;
    } exp_t;

    // Inputs (k, t, l, rev, stall window, poke start) and expected
    // outputs (err, done cycle) of one run.
    typedef struct {
        int k;
        int t;
        int l;
        bit rev;
        int slo;
        int shi;
        bit poke;
        bit exp_err;
        int exp_done;
    } vec_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string tag = "";

    function automatic exp_t idle(bit chk);
        exp_t x;
        x.en = '0; x.first = '0; x.last = '0; x.tile = '0;
        x.chk_tile = chk; x.busy = 1'b0; x.done = 1'b0; x.err = 1'b0;
        return x;
    endfunction

    // Expected outputs at cycle c of a run; cycles after 'cut' are the
    // flushed state. Stalled cycles repeat the previous cycle.
    function automatic exp_t exp_at(int k, int t, int l, bit rev,
                                    int slo, int shi, int dn, bit er,
                                    int cut, int c);
        exp_t x;
        int   e;
        int   d;
        x = idle(1'b0);
        if (cut > 0 && c > cut) begin
            x.chk_tile = 1'b1;
            return x;
        end
        if (er) begin
            x.err = (c == 1);
            return x;
        end
        e = c;
        if (slo > 0) begin
            for (int s = slo; s <= shi; s++) begin
                if (s < c) e--;
            end
        end
        for (int i = 0; i < l; i++) begin
            d = rev ? l - 1 - i : i;
            if (e >= 1 + d && e <= t * k + d) begin
                x.en[i]    = 1'b1;
                x.first[i] = ((e - 1 - d) % k == 0);
                x.last[i]  = ((e - d) % k == 0);
            end
        end
        x.busy     = (c >= 1 && c < dn);
        x.done     = (c == dn);
        x.chk_tile = (e >= 1 && e <= t * k);
        if (x.chk_tile) x.tile = TILE_W'((e - 1) / k);
        return x;
    endfunction

    task automatic check_out();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expectation queued at %0t", tag, $time);
            return;
        end
        x = sb.pop_front();
        if (lane_en !== x.en || lane_first !== x.first ||
            lane_last !== x.last || busy !== x.busy ||
            done !== x.done || err !== x.err ||
            (x.chk_tile && tile_idx !== x.tile)) begin
            errors++;
            $display("FAIL %s @%0t: got en=%b first=%b last=%b tile=%0d busy=%b done=%b err=%b, want en=%b first=%b last=%b tile=%0d(chk=%0d) busy=%b done=%b err=%b",
                     tag, $time, lane_en, lane_first, lane_last, tile_idx,
                     busy, done, err, x.en, x.first, x.last, x.tile,
                     x.chk_tile, x.busy, x.done, x.err);
        end
    endtask

    task automatic cyc(input bit st, input bit stl, input bit ab,
                       input bit rn);
        start = st;
        stall = stl;
        abort = ab;
        rst_n = rn;
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int k, input int t, input int l,
                           input bit rev);
        cfg_len     = LEN_W'(k);
        cfg_tiles   = TILE_W'(t);
        cfg_lanes   = LW'(l);
        cfg_reverse = rev;
    endtask

    task automatic scramble();
        cfg_len     = LEN_W'($urandom);
        cfg_tiles   = TILE_W'($urandom);
        cfg_lanes   = LW'($urandom);
        cfg_reverse = 1'($urandom);
    endtask

    task automatic push_run(input int k, input int t, input int l,
                            input bit rev, input int dn, input int cut,
                            input int n);
        for (int c = 1; c <= n; c++) begin
            sb.push_back(exp_at(k, t, l, rev, 0, 0, dn, 1'b0, cut, c));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[10];
        vec_t v;
        int   n;
        vecs[0] = '{3, 1, 4, 1'b0, 0, 0, 1'b0, 1'b0, 7};
        vecs[1] = '{3, 2, 4, 1'b0, 0, 0, 1'b1, 1'b0, 10};
        vecs[2] = '{3, 1, 3, 1'b1, 0, 0, 1'b0, 1'b0, 6};
        vecs[3] = '{3, 1, 4, 1'b0, 2, 3, 1'b0, 1'b0, 9};
        vecs[4] = '{1, 2, 2, 1'b0, 0, 0, 1'b0, 1'b0, 4};
        vecs[5] = '{2, 3, 1, 1'b1, 0, 0, 1'b0, 1'b0, 7};
        vecs[6] = '{3, 1, 5, 1'b0, 0, 0, 1'b0, 1'b1, 0};
        vecs[7] = '{0, 1, 4, 1'b0, 0, 0, 1'b0, 1'b1, 0};
        vecs[8] = '{2, 0, 2, 1'b0, 0, 0, 1'b0, 1'b1, 0};
        vecs[9] = '{4, 2, 4, 1'b1, 5, 5, 1'b0, 1'b0, 13};

        repeat (2) @(posedge clk);
        #1;
        tag = "reset";
        sb.push_back(idle(1'b1));
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        for (int vi = 0; vi < 10; vi++) begin
            v   = vecs[vi];
            tag = $sformatf("vec%0d", vi);
            n   = v.exp_err ? 2 : v.exp_done + 1;
            set_cfg(v.k, v.t, v.l, v.rev);
            sb.push_back(idle(1'b0));
            for (int c = 1; c <= n; c++) begin
                sb.push_back(exp_at(v.k, v.t, v.l, v.rev, v.slo, v.shi,
                                    v.exp_done, v.exp_err, 0, c));
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            scramble();
            for (int c = 1; c <= n; c++) begin
                cyc(v.poke && c == 2,
                    v.slo > 0 && c >= v.slo && c <= v.shi,
                    1'b0, 1'b1);
            end
        end

        // Zero-gap restart from the done cycle, into a wider run.
        tag = "b2b";
        set_cfg(2, 1, 2, 1'b0);
        sb.push_back(idle(1'b0));
        push_run(2, 1, 2, 1'b0, 4, 0, 4);
        push_run(1, 2, 4, 1'b0, 6, 0, 7);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        set_cfg(1, 2, 4, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 7; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Abort (with stall also high) in cycle 3, then a fresh run.
        tag = "abort";
        set_cfg(3, 1, 4, 1'b0);
        sb.push_back(idle(1'b0));
        push_run(3, 1, 4, 1'b0, 7, 3, 8);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b0, c == 3, c == 3, 1'b1);
        end
        tag = "post_abort";
        set_cfg(1, 1, 1, 1'b0);
        sb.push_back(idle(1'b1));
        push_run(1, 1, 1, 1'b0, 2, 0, 3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 3; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Synchronous reset in cycle 3, then a fresh run.
        tag = "midreset";
        set_cfg(3, 1, 4, 1'b1);
        sb.push_back(idle(1'b0));
        push_run(3, 1, 4, 1'b1, 7, 3, 8);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b0, 1'b0, 1'b0, c != 3);
        end
        tag = "post_reset";
        set_cfg(2, 1, 3, 1'b0);
        sb.push_back(idle(1'b1));
        push_run(2, 1, 3, 1'b0, 5, 0, 6);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        scramble();
        for (int c = 1; c <= 6; c++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
